busca_instrucao: RTL and testbench
==================================

# busca_instrucao

Instruction fetch stage of the multicycle CPU, sitting directly upstream of the `Controle` unit. It owns the program counter and instruction register, fetches 16-bit instructions from instruction memory over a req/ack handshake, and presents the decoded fields (opcode first) to the controller. It consumes the controller's PC-write signals (`EscCP`, `EscCondCP`, `FonteCP`) together with the ALU zero flag and ALU result to compute the next PC.

## Interface

Parameters:

- `LARGURA_PC`, 8, width of the PC and memory address
- `LARGURA_CONT`, 16, width of the retired-instruction counter

Ports:

- `clk`, in, 1, single clock; all state updates on the rising edge
- `rst`, in, 1, asynchronous reset, active-high
- `mem_req`, out, 1, fetch request to instruction memory
- `mem_end`, out, LARGURA_PC, fetch address; always equals `pc`
- `mem_ack`, in, 1, memory has data valid on `mem_dado` this cycle
- `mem_dado`, in, 16, instruction word
- `opcode`, out, 4, IR[15:12]
- `rd`, out, 4, IR[11:8]
- `rs`, out, 4, IR[7:4]
- `rt`, out, 4, IR[3:0]
- `imm`, out, 8, IR[7:0]
- `instr_valido`, out, 1, IR holds the current instruction for the controller
- `conclui`, in, 1, controller pulse: current instruction finished; apply PC update
- `EscCP`, in, 1, PC write enable
- `EscCondCP`, in, 1, PC write is conditional on `zero`
- `FonteCP`, in, 2, next-PC source
- `zero`, in, 1, ALU zero flag
- `alvo_ula`, in, LARGURA_PC, ALU-computed branch target
- `pc`, out, LARGURA_PC, current PC
- `cont_instr`, out, LARGURA_CONT, number of retired instructions

## Operation

The block has three states: INICIO, BUSCA and VALIDO.

- **Reset (async):** state goes to INICIO. `pc`=0, IR=0, `cont_instr`=0. All outputs drop immediately: `mem_req`=0, `instr_valido`=0, and the fields read 0.
- **INICIO:** no request is issued. Moves unconditionally to BUSCA on the next edge.
- **BUSCA:**
  - `mem_req`=1 and `mem_end`=`pc`, both held stable until `mem_ack` is sampled high.
  - On `mem_ack`=1, IR is loaded from `mem_dado` and the state moves to VALIDO.
  - `conclui` is ignored in this state.
- **VALIDO:**
  - `instr_valido`=1 and `mem_req`=0. The IR is frozen.
  - `mem_ack` is ignored.
  - On `conclui`=1, the PC update is applied, `cont_instr` is incremented, and the state moves to BUSCA.
- **Next-PC rule** (evaluated only on `conclui` in VALIDO):
  - `EscCP`=0: PC holds, and the same address is re-fetched (used as halt/spin).
  - `EscCP`=1, `EscCondCP`=1, `zero`=0: condition fails, PC ← PC+1.
  - Otherwise PC is selected by `FonteCP`:
    - 00: PC+1
    - 01: `alvo_ula`
    - 10: `imm`, zero-extended or truncated to LARGURA_PC (jump)
    - 11: reserved, treated as 00
- **Arithmetic:**
  - PC+1 wraps modulo 2^LARGURA_PC; for example, 0xFF wraps to 0x00 at width 8.
  - `cont_instr` saturates at its all-ones value and does not wrap.
- The decoded fields are pure slices of the IR and are stable for the whole of VALIDO.

## Timing

- First `mem_req`=1 occurs in the second cycle after `rst` deasserts.
- If `mem_ack` is sampled in cycle k, `instr_valido`=1 and the new fields appear in cycle k+1.
- If `conclui` is sampled in cycle j, the new `pc` and `mem_req`=1 appear in cycle j+1.
- Minimum instruction period is 2 cycles, when `mem_ack` arrives in the first BUSCA cycle and `conclui` in the first VALIDO cycle.
- `mem_ack` may arrive in the same cycle that `mem_req` first rises; there is no bubble.
- `conclui` and `mem_ack` asserted together are handled per state; only the one relevant to the current state acts.
- Reset during BUSCA with an outstanding request: the request is abandoned and a late `mem_ack` is ignored, because the block is in INICIO.
- Reset during VALIDO: the pending PC update is lost.

## Structure

- Shared package `pacote_cpu`:
  - opcode constants 0–12 (including the jump opcode 11 and the branch opcode 12)
  - `FonteCP` encodings (PC_MAIS1=00, PC_ULA=01, PC_SALTO=10)
  - the state encoding (INICIO, BUSCA, VALIDO)
- One sub-module, `registrador_pc`, implements the PC register, the next-PC mux and the condition logic. Its inputs are `conclui`-qualified enable, `EscCP`, `EscCondCP`, `zero`, `FonteCP`, `alvo_ula` and `imm`.
- The FSM, IR and counter live in the top-level module.

## Test plan

- **Reset then fetch:** release `rst`; memory acks the first request with 0x1234 in the same cycle.
  - `mem_end`=0x00.
  - Next cycle: `opcode`=1, `rd`=2, `rs`=3, `rt`=4, `instr_valido`=1.
- **Sequential advance:** `conclui` with `EscCP`=1, `EscCondCP`=0, `FonteCP`=00 at pc=0x05.
  - Next cycle: `pc`=0x06, `mem_req`=1, `cont_instr`+1.
- **Jump:** IR=0xB0_2A, `conclui` with `EscCP`=1, `FonteCP`=10 → `pc`=0x2A.
- **Branch on zero** with `EscCondCP`=1, `FonteCP`=01, `alvo_ula`=0x40:
  - `zero`=1 → `pc`=0x40.
  - `zero`=0 → `pc`=old+1.
- **Wait states and wrap:** ack delayed 3 cycles.
  - `mem_req` and `mem_end` stay stable through the wait.
  - At pc=0xFF a sequential advance gives `pc`=0x00.
  - `conclui` pulsed during BUSCA has no effect.
- **Reset mid-fetch:** assert `rst` while `mem_req`=1, then ack 1 cycle later.
  - Immediately `mem_req`=0 and `pc`=0.
  - The late ack is ignored and IR stays 0.

Source files
------------

// File: rtl/busca_instrucao_pkg.sv
// Shared CPU definitions: opcodes, next-PC source encodings and the fetch-stage state encoding.
package pacote_cpu;

  localparam logic [3:0] OP_SOMA     = 4'd0;
  localparam logic [3:0] OP_SUB      = 4'd1;
  localparam logic [3:0] OP_E        = 4'd2;
  localparam logic [3:0] OP_OU       = 4'd3;
  localparam logic [3:0] OP_XOU      = 4'd4;
  localparam logic [3:0] OP_SLT      = 4'd5;
  localparam logic [3:0] OP_SOMAI    = 4'd6;
  localparam logic [3:0] OP_CARREGA  = 4'd7;
  localparam logic [3:0] OP_ARMAZENA = 4'd8;
  localparam logic [3:0] OP_DESL_E   = 4'd9;
  localparam logic [3:0] OP_DESL_D   = 4'd10;
  localparam logic [3:0] OP_SALTO    = 4'd11;
  localparam logic [3:0] OP_DESVIO   = 4'd12;

  typedef enum logic [1:0] {
    PC_MAIS1     = 2'b00,
    PC_ULA       = 2'b01,
    PC_SALTO     = 2'b10,
    PC_RESERVADO = 2'b11
  } fonte_cp_t;

  typedef enum logic [1:0] {
    INICIO = 2'b00,
    BUSCA  = 2'b01,
    VALIDO = 2'b10
  } estado_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and memory (slave).
interface busca_instrucao_if #(
  parameter int LARGURA_PC = 8
) ();

  logic                  mem_req;
  logic [LARGURA_PC-1:0] mem_end;
  logic                  mem_ack;
  logic [15:0]           mem_dado;

  modport master (output mem_req, output mem_end, input mem_ack, input mem_dado);
  modport slave  (input mem_req, input mem_end, output mem_ack, output mem_dado);

endinterface

// File: rtl/busca_instrucao_registrador_pc.sv
// Program counter register with next-PC selection and branch-condition logic.
module registrador_pc
  import pacote_cpu::*;
#(
  parameter int LARGURA_PC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  habilita,
  input  logic                  EscCP,
  input  logic                  EscCondCP,
  input  logic                  zero,
  input  logic [1:0]            FonteCP,
  input  logic [LARGURA_PC-1:0] alvo_ula,
  input  logic [7:0]            imm,
  output logic [LARGURA_PC-1:0] pc
);

  logic [LARGURA_PC-1:0]   pc_r;
  logic [LARGURA_PC-1:0]   pc_mais1_s;
  logic [LARGURA_PC-1:0]   imm_ext_s;
  logic [LARGURA_PC+7:0]   imm_larga_s;
  logic [LARGURA_PC-1:0]   proximo_s;

  // Widening first makes the zero-extend/truncate work for any PC width.
  assign imm_larga_s = {{LARGURA_PC{1'b0}}, imm};
  assign imm_ext_s   = imm_larga_s[LARGURA_PC-1:0];
  assign pc_mais1_s  = pc_r + {{(LARGURA_PC-1){1'b0}}, 1'b1};

  // Next-PC selection; a failed conditional branch falls through to PC+1.
  always_comb begin
    proximo_s = pc_r;
    if (!EscCP) begin
      proximo_s = pc_r;
    end else if (EscCondCP && !zero) begin
      proximo_s = pc_mais1_s;
    end else begin
      case (FonteCP)
        PC_MAIS1: proximo_s = pc_mais1_s;
        PC_ULA:   proximo_s = alvo_ula;
        PC_SALTO: proximo_s = imm_ext_s;
        default:  proximo_s = pc_mais1_s;
      endcase
    end
  end

  // PC register, updated only when the controller retires an instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= {LARGURA_PC{1'b0}};
    end else if (habilita) begin
      pc_r <= proximo_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: fetch FSM, instruction register and retired-instruction counter.
module busca_instrucao
  import pacote_cpu::*;
#(
  parameter int LARGURA_PC   = 8,
  parameter int LARGURA_CONT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  busca_instrucao_if.master       mem,
  output logic [3:0]              opcode,
  output logic [3:0]              rd,
  output logic [3:0]              rs,
  output logic [3:0]              rt,
  output logic [7:0]              imm,
  output logic                    instr_valido,
  input  logic                    conclui,
  input  logic                    EscCP,
  input  logic                    EscCondCP,
  input  logic [1:0]              FonteCP,
  input  logic                    zero,
  input  logic [LARGURA_PC-1:0]   alvo_ula,
  output logic [LARGURA_PC-1:0]   pc,
  output logic [LARGURA_CONT-1:0] cont_instr
);

  estado_t                 estado_r;
  logic                    mem_req_r;
  logic                    instr_valido_r;
  logic [15:0]             ir_r;
  logic [LARGURA_CONT-1:0] cont_instr_r;
  logic                    atualiza_pc_s;
  logic [LARGURA_PC-1:0]   pc_s;

  assign atualiza_pc_s = conclui && (estado_r == VALIDO);

  registrador_pc #(
    .LARGURA_PC (LARGURA_PC)
  ) u_registrador_pc (
    .clk       (clk),
    .rst       (rst),
    .habilita  (atualiza_pc_s),
    .EscCP     (EscCP),
    .EscCondCP (EscCondCP),
    .zero      (zero),
    .FonteCP   (FonteCP),
    .alvo_ula  (alvo_ula),
    .imm       (ir_r[7:0]),
    .pc        (pc_s)
  );

  // Fetch FSM with registered request/valid flags, IR load and saturating retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_r       <= INICIO;
      mem_req_r      <= 1'b0;
      instr_valido_r <= 1'b0;
      ir_r           <= 16'h0000;
      cont_instr_r   <= {LARGURA_CONT{1'b0}};
    end else begin
      case (estado_r)
        INICIO: begin
          estado_r       <= BUSCA;
          mem_req_r      <= 1'b1;
          instr_valido_r <= 1'b0;
        end
        BUSCA: begin
          if (mem.mem_ack) begin
            ir_r           <= mem.mem_dado;
            estado_r       <= VALIDO;
            mem_req_r      <= 1'b0;
            instr_valido_r <= 1'b1;
          end else begin
            mem_req_r      <= 1'b1;
            instr_valido_r <= 1'b0;
          end
        end
        VALIDO: begin
          if (conclui) begin
            estado_r       <= BUSCA;
            mem_req_r      <= 1'b1;
            instr_valido_r <= 1'b0;
            if (cont_instr_r != {LARGURA_CONT{1'b1}}) begin
              cont_instr_r <= cont_instr_r + {{(LARGURA_CONT-1){1'b0}}, 1'b1};
            end else begin
              cont_instr_r <= cont_instr_r;
            end
          end else begin
            mem_req_r      <= 1'b0;
            instr_valido_r <= 1'b1;
          end
        end
        default: begin
          estado_r       <= INICIO;
          mem_req_r      <= 1'b0;
          instr_valido_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req  = mem_req_r;
  assign mem.mem_end  = pc_s;
  assign pc           = pc_s;
  assign instr_valido = instr_valido_r;
  assign cont_instr   = cont_instr_r;
  assign opcode       = ir_r[15:12];
  assign rd           = ir_r[11:8];
  assign rs           = ir_r[7:4];
  assign rt           = ir_r[3:0];
  assign imm          = ir_r[7:0];

endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao: fetched words are queued at ack and checked when the IR turns valid.
module tb_busca_instrucao;
  import pacote_cpu::*;

  localparam int LPC = 8;
  localparam int LC  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           conclui;
  logic           EscCP;
  logic           EscCondCP;
  logic [1:0]     FonteCP;
  logic           zero;
  logic [LPC-1:0] alvo_ula;
  logic [LPC-1:0] pc;
  logic [LC-1:0]  cont_instr;
  logic [3:0]     opcode, rd, rs, rt;
  logic [7:0]     imm;
  logic           instr_valido;

  busca_instrucao_if #(.LARGURA_PC(LPC)) mem_if ();

  busca_instrucao #(
    .LARGURA_PC   (LPC),
    .LARGURA_CONT (LC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (mem_if),
    .opcode       (opcode),
    .rd           (rd),
    .rs           (rs),
    .rt           (rt),
    .imm          (imm),
    .instr_valido (instr_valido),
    .conclui      (conclui),
    .EscCP        (EscCP),
    .EscCondCP    (EscCondCP),
    .FonteCP      (FonteCP),
    .zero         (zero),
    .alvo_ula     (alvo_ula),
    .pc           (pc),
    .cont_instr   (cont_instr)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_erros  = 0;
  logic [15:0] sb_q[$];
  logic [15:0] ir_mod;
  logic [7:0]  pc_mod;
  logic [15:0] cont_mod;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: obtido=0x%0h esperado=0x%0h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busca(input logic [15:0] dado, input int atraso, input bit conclui_espurio);
    int n;
    logic [15:0] esp;
    n = 0;
    while (mem_if.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    verifica("req_ativo", {31'd0, mem_if.mem_req}, 32'd1);
    verifica("mem_end", {24'd0, mem_if.mem_end}, {24'd0, pc_mod});
    for (int i = 0; i < atraso; i++) begin
      if (conclui_espurio && i == 0) begin
        conclui = 1'b1; EscCP = 1'b1; EscCondCP = 1'b0; FonteCP = PC_ULA; alvo_ula = 8'h77;
      end
      tick();
      conclui = 1'b0;
      verifica("req_espera", {31'd0, mem_if.mem_req}, 32'd1);
      verifica("end_espera", {24'd0, mem_if.mem_end}, {24'd0, pc_mod});
      verifica("pc_espera", {24'd0, pc}, {24'd0, pc_mod});
      verifica("cont_espera", {16'd0, cont_instr}, {16'd0, cont_mod});
      verifica("valido_espera", {31'd0, instr_valido}, 32'd0);
    end
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_dado = dado;
    sb_q.push_back(dado);
    tick();
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_dado = 16'h0000;
    verifica("instr_valido", {31'd0, instr_valido}, 32'd1);
    verifica("req_baixo", {31'd0, mem_if.mem_req}, 32'd0);
    verifica("sb_ocupacao", sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      esp    = sb_q.pop_front();
      ir_mod = esp;
      verifica("opcode", {28'd0, opcode}, {28'd0, esp[15:12]});
      verifica("rd", {28'd0, rd}, {28'd0, esp[11:8]});
      verifica("rs", {28'd0, rs}, {28'd0, esp[7:4]});
      verifica("rt", {28'd0, rt}, {28'd0, esp[3:0]});
      verifica("imm", {24'd0, imm}, {24'd0, esp[7:0]});
    end
  endtask

  task automatic retira(input logic esc, input logic cond, input logic z,
                        input logic [1:0] fonte, input logic [7:0] alvo, input bit ack_junto);
    if (!esc) begin
      pc_mod = pc_mod;
    end else if (cond && !z) begin
      pc_mod = pc_mod + 8'd1;
    end else if (fonte == 2'b01) begin
      pc_mod = alvo;
    end else if (fonte == 2'b10) begin
      pc_mod = ir_mod[7:0];
    end else begin
      pc_mod = pc_mod + 8'd1;
    end
    if (cont_mod != 16'hFFFF) cont_mod = cont_mod + 16'd1;
    conclui = 1'b1; EscCP = esc; EscCondCP = cond; zero = z; FonteCP = fonte; alvo_ula = alvo;
    if (ack_junto) begin
      mem_if.mem_ack = 1'b1; mem_if.mem_dado = 16'hDEAD;
    end
    tick();
    conclui = 1'b0; EscCP = 1'b0; EscCondCP = 1'b0; zero = 1'b0; FonteCP = 2'b00;
    mem_if.mem_ack = 1'b0; mem_if.mem_dado = 16'h0000;
    verifica("pc_novo", {24'd0, pc}, {24'd0, pc_mod});
    verifica("req_apos_conclui", {31'd0, mem_if.mem_req}, 32'd1);
    verifica("valido_apos_conclui", {31'd0, instr_valido}, 32'd0);
    verifica("cont_instr", {16'd0, cont_instr}, {16'd0, cont_mod});
    verifica("ir_congelado", {28'd0, opcode}, {28'd0, ir_mod[15:12]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: obtido=timeout esperado=fim");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; conclui = 1'b0; EscCP = 1'b0; EscCondCP = 1'b0; FonteCP = 2'b00;
    zero = 1'b0; alvo_ula = 8'h00;
    mem_if.mem_ack = 1'b0; mem_if.mem_dado = 16'h0000;
    pc_mod = 8'h00; cont_mod = 16'h0000; ir_mod = 16'h0000;
    tick(); tick();
    verifica("rst_pc", {24'd0, pc}, 32'd0);
    verifica("rst_req", {31'd0, mem_if.mem_req}, 32'd0);
    verifica("rst_valido", {31'd0, instr_valido}, 32'd0);
    verifica("rst_opcode", {28'd0, opcode}, 32'd0);
    verifica("rst_cont", {16'd0, cont_instr}, 32'd0);
    rst = 1'b0;
    verifica("inicio_sem_req", {31'd0, mem_if.mem_req}, 32'd0);
    tick();
    verifica("primeiro_req", {31'd0, mem_if.mem_req}, 32'd1);

    busca(16'h1234, 0, 1'b0);
    retira(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);   // pc 0x01
    busca(16'hB005, 1, 1'b0);
    retira(1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b1);   // jump to 0x05, ack ignored
    busca(16'h1111, 0, 1'b0);
    retira(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);   // 0x05 -> 0x06
    busca(16'hB02A, 2, 1'b0);
    retira(1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0);   // 0x2A
    busca(16'hC000, 0, 1'b0);
    retira(1'b1, 1'b1, 1'b1, 2'b01, 8'h40, 1'b0);   // taken -> 0x40
    busca(16'hC000, 0, 1'b0);
    retira(1'b1, 1'b1, 1'b0, 2'b01, 8'h40, 1'b0);   // not taken -> 0x41
    busca(16'h0000, 0, 1'b0);
    retira(1'b0, 1'b0, 1'b0, 2'b01, 8'h99, 1'b0);   // halt: stays 0x41
    busca(16'h5678, 0, 1'b0);
    retira(1'b1, 1'b0, 1'b0, 2'b11, 8'h99, 1'b0);   // reserved -> 0x42
    busca(16'hB0FF, 0, 1'b0);
    retira(1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0);   // 0xFF
    busca(16'h9ABC, 3, 1'b1);
    retira(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);   // wrap 0xFF -> 0x00
    busca(16'hB010, 0, 1'b0);
    retira(1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0);   // 0x10, now in BUSCA with req high

    verifica("req_antes_rst", {31'd0, mem_if.mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    pc_mod = 8'h00; cont_mod = 16'h0000; ir_mod = 16'h0000;
    sb_q.delete();
    verifica("rst_meio_req", {31'd0, mem_if.mem_req}, 32'd0);
    verifica("rst_meio_pc", {24'd0, pc}, 32'd0);
    verifica("rst_meio_cont", {16'd0, cont_instr}, 32'd0);
    tick();
    rst = 1'b0;
    mem_if.mem_ack = 1'b1; mem_if.mem_dado = 16'hFFFF;
    tick();
    mem_if.mem_ack = 1'b0; mem_if.mem_dado = 16'h0000;
    verifica("ack_tardio_ir", {24'd0, imm}, 32'd0);
    verifica("ack_tardio_opcode", {28'd0, opcode}, 32'd0);
    verifica("ack_tardio_valido", {31'd0, instr_valido}, 32'd0);
    verifica("req_pos_rst", {31'd0, mem_if.mem_req}, 32'd1);
    busca(16'h2345, 1, 1'b0);
    retira(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);   // 0x00 -> 0x01

    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

endmodule
